// File: rtl/microwave_pkg.sv
// rtl/microwave_pkg.sv - shared state encoding and BCD constants for the countdown stage
package microwave_pkg;

  localparam int DIGIT_W = 4;

  typedef logic [DIGIT_W-1:0] bcd_t;

  localparam bcd_t BCD_UNITS_MAX = 4'd9;
  localparam bcd_t BCD_TENS_MAX  = 4'd5;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUNNING = 2'd1,
    ST_PAUSED  = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  function automatic logic digits_valid(input bcd_t m, input bcd_t t, input bcd_t u);
    return (m <= BCD_UNITS_MAX) && (t <= BCD_TENS_MAX) && (u <= BCD_UNITS_MAX);
  endfunction

endpackage

// File: rtl/sec_prescaler.sv
// rtl/sec_prescaler.sv - divides clk down to a one-cycle tick every TICKS_PER_SEC enabled cycles
module sec_prescaler #(
  parameter int TICKS_PER_SEC = 100_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int CW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICKS_PER_SEC - 1);

  logic [CW-1:0] cnt;

  assign tick = en && (cnt == LAST);

  // Holding the count while en is low is what lets a resumed run finish the interrupted second.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tick ? '0 : cnt + CW'(1);
    end
  end

endmodule

// File: rtl/microwave_countdown.sv
// rtl/microwave_countdown.sv - m:ss countdown FSM with heater, done and beep; DOOR_INTERLOCK_EN adds door pause
module microwave_countdown
  import microwave_pkg::*;
#(
  parameter int TICKS_PER_SEC = 100_000_000,
  parameter int BEEP_SEC      = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [DIGIT_W-1:0] units_of_minutes,
  input  logic [DIGIT_W-1:0] tens_of_seconds,
  input  logic [DIGIT_W-1:0] units_of_seconds,
  input  logic               start,
  input  logic               stop,
  input  logic               clear,
  input  logic               door_open,
  output logic [DIGIT_W-1:0] rem_min,
  output logic [DIGIT_W-1:0] rem_tens,
  output logic [DIGIT_W-1:0] rem_units,
  output logic               heater,
  output logic               done,
  output logic               beep,
  output logic               input_err,
  output logic [1:0]         state
);

  localparam int BW = (BEEP_SEC > 1) ? $clog2(BEEP_SEC) : 1;
  localparam logic [BW-1:0] BEEP_LAST = BW'(BEEP_SEC - 1);

  state_t        state_q, state_d;
  bcd_t          min_d, tens_d, units_d;
  bcd_t          dec_m, dec_t, dec_u;
  logic          err_d;
  logic          tick;
  logic          door_hold;
  logic          go;
  logic          dec_zero;
  logic          loaded_zero;
  logic [BW-1:0] beep_cnt;

`ifdef DOOR_INTERLOCK_EN
  assign door_hold = door_open;
`else
  logic unused_door;
  assign door_hold   = 1'b0;
  assign unused_door = door_open;
`endif

  function automatic logic [3*DIGIT_W-1:0] bcd_dec(input bcd_t m, input bcd_t t, input bcd_t u);
    bcd_t dm, dt, du;
    dm = m;
    dt = t;
    du = u;
    if (u != '0) begin
      du = u - bcd_t'(1);
    end else if (t != '0) begin
      dt = t - bcd_t'(1);
      du = BCD_UNITS_MAX;
    end else begin
      dm = m - bcd_t'(1);
      dt = BCD_TENS_MAX;
      du = BCD_UNITS_MAX;
    end
    return {dm, dt, du};
  endfunction

  assign {dec_m, dec_t, dec_u} = bcd_dec(rem_min, rem_tens, rem_units);
  assign dec_zero    = ({dec_m, dec_t, dec_u} == '0);
  assign loaded_zero = ({rem_min, rem_tens, rem_units} == '0);
  assign go          = start && !stop && !clear && !door_hold;
  assign state       = state_q;

  sec_prescaler #(
    .TICKS_PER_SEC(TICKS_PER_SEC)
  ) u_prescaler (
    .clk (clk),
    .rst (rst),
    .clr (state_q == ST_IDLE),
    .en  ((state_q == ST_RUNNING) || (state_q == ST_DONE)),
    .tick(tick)
  );

  always_comb begin
    state_d = state_q;
    min_d   = rem_min;
    tens_d  = rem_tens;
    units_d = rem_units;
    err_d   = input_err;
    case (state_q)
      ST_IDLE: begin
        if (go && !input_err && !loaded_zero) state_d = ST_RUNNING;
      end
      ST_RUNNING: begin
        if (clear) begin
          state_d = ST_IDLE;
        end else begin
          // The tick lands even when a pause arrives with it, so a last-second pause still finishes.
          if (tick) begin
            min_d   = dec_m;
            tens_d  = dec_t;
            units_d = dec_u;
          end
          if (tick && dec_zero) state_d = ST_DONE;
          else if (stop || door_hold) state_d = ST_PAUSED;
        end
      end
      ST_PAUSED: begin
        if (clear) state_d = ST_IDLE;
        else if (go) state_d = ST_RUNNING;
      end
      ST_DONE: begin
        min_d   = '0;
        tens_d  = '0;
        units_d = '0;
        if (start || clear || (tick && beep_cnt == BEEP_LAST)) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (state_d == ST_IDLE) begin
      min_d   = units_of_minutes;
      tens_d  = tens_of_seconds;
      units_d = units_of_seconds;
      err_d   = !digits_valid(units_of_minutes, tens_of_seconds, units_of_seconds);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      rem_min   <= '0;
      rem_tens  <= '0;
      rem_units <= '0;
      input_err <= 1'b0;
      heater    <= 1'b0;
      done      <= 1'b0;
      beep      <= 1'b0;
      beep_cnt  <= '0;
    end else begin
      state_q   <= state_d;
      rem_min   <= min_d;
      rem_tens  <= tens_d;
      rem_units <= units_d;
      input_err <= err_d;
      heater    <= (state_d == ST_RUNNING);
      done      <= (state_q == ST_RUNNING) && (state_d == ST_DONE);
      beep      <= (state_d == ST_DONE);
      if (state_q != ST_DONE) beep_cnt <= '0;
      else if (tick) beep_cnt <= beep_cnt + BW'(1);
    end
  end

endmodule

// File: tb/tb_microwave_countdown.sv
// tb/tb_microwave_countdown.sv - directed and randomized checks of microwave_countdown against a seconds-level model
module tb_microwave_countdown;

  localparam int T  = 4;
  localparam int B  = 2;
  localparam int MI = 0;
  localparam int MR = 1;
  localparam int MP = 2;
  localparam int MD = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] units_of_minutes = '0;
  logic [3:0] tens_of_seconds  = '0;
  logic [3:0] units_of_seconds = '0;
  logic       start = 1'b0;
  logic       stop  = 1'b0;
  logic       clear = 1'b0;
  logic       door_open = 1'b0;
  logic [3:0] rem_min, rem_tens, rem_units;
  logic       heater, done, beep, input_err;
  logic [1:0] state;

  int n_cmp = 0;
  int n_bad = 0;

  int m_st, m_total, m_el, m_bel, lm, lt, lu;
  bit m_err, m_done;

  always #5 clk = ~clk;

  microwave_countdown #(
    .TICKS_PER_SEC(T),
    .BEEP_SEC(B)
  ) dut (
    .clk(clk),
    .rst(rst),
    .units_of_minutes(units_of_minutes),
    .tens_of_seconds(tens_of_seconds),
    .units_of_seconds(units_of_seconds),
    .start(start),
    .stop(stop),
    .clear(clear),
    .door_open(door_open),
    .rem_min(rem_min),
    .rem_tens(rem_tens),
    .rem_units(rem_units),
    .heater(heater),
    .done(done),
    .beep(beep),
    .input_err(input_err),
    .state(state)
  );

  function automatic logic [17:0] actual();
    return {state, rem_min, rem_tens, rem_units, heater, done, beep, input_err};
  endfunction

  function automatic logic [17:0] expected();
    int s;
    logic [3:0] em, et, eu;
    s = 0;
    case (m_st)
      MI: begin em = 4'(lm); et = 4'(lt); eu = 4'(lu); end
      MR, MP: begin
        s  = m_total - m_el / T;
        em = 4'(s / 60);
        et = 4'((s % 60) / 10);
        eu = 4'(s % 10);
      end
      default: begin em = 4'd0; et = 4'd0; eu = 4'd0; end
    endcase
    return {2'(m_st), em, et, eu, (m_st == MR), m_done, (m_st == MD), m_err};
  endfunction

  task automatic model_init();
    m_st = MI; m_total = 0; m_el = 0; m_bel = 0;
    lm = 0; lt = 0; lu = 0; m_err = 0; m_done = 0;
  endtask

  // Time kept as whole seconds plus running cycles; a second elapses every T running cycles.
  task automatic model_edge();
    bit blk;
`ifdef DOOR_INTERLOCK_EN
    blk = door_open;
`else
    blk = 1'b0;
`endif
    m_done = 0;
    case (m_st)
      MI: if (start && !stop && !clear && !blk && !m_err && (lm * 60 + lt * 10 + lu) > 0) begin
        m_st = MR; m_total = lm * 60 + lt * 10 + lu; m_el = 0;
      end
      MR: if (clear) m_st = MI;
          else begin
            m_el++;
            if (m_total - m_el / T == 0) begin m_st = MD; m_done = 1; m_bel = 0; end
            else if (stop || blk) m_st = MP;
          end
      MP: if (clear) m_st = MI;
          else if (start && !stop && !blk) m_st = MR;
      default: begin
        m_bel++;
        if (start || clear || m_bel == B * T) m_st = MI;
      end
    endcase
    if (m_st == MI) begin
      lm = units_of_minutes; lt = tens_of_seconds; lu = units_of_seconds;
      m_err = (lm > 9) || (lt > 5) || (lu > 9);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic set_time(input int m, input int t, input int u);
    units_of_minutes = 4'(m);
    tens_of_seconds  = 4'(t);
    units_of_seconds = 4'(u);
  endtask

  task automatic settle();
    clear = 1'b1; cycle(); clear = 1'b0; cycle();
  endtask

  task automatic begin_run(input int m, input int t, input int u);
    settle();
    set_time(m, t, u);
    cycle(); cycle();
    start = 1'b1; cycle(); start = 1'b0;
  endtask

  task automatic test_reset();
    set_time(2, 3, 4);
    start = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    n_cmp++;
    if (actual() !== 18'd0) begin
      n_bad++; $display("FAIL reset_hold: got %h expected %h", actual(), 18'd0);
    end
    start = 1'b0;
    rst = 1'b1;
    model_init();
    cycle();
    n_cmp++;
    if ({rem_min, rem_tens, rem_units, state} !== {12'h234, 2'd0}) begin
      n_bad++; $display("FAIL idle_load: got %h expected %h", {rem_min, rem_tens, rem_units, state}, {12'h234, 2'd0});
    end
  endtask

  task automatic test_full_run();
    int done_k, beep_n, done_n;
    begin_run(1, 0, 5);
    n_cmp++;
    if ({state, heater} !== 3'b011) begin
      n_bad++; $display("FAIL run_entry: got %b expected %b", {state, heater}, 3'b011);
    end
    done_k = -1;
    for (int k = 1; k <= 300; k++) begin
      cycle();
      if (k == 4 || k == 20 || k == 24) begin
        n_cmp++;
        if ({rem_min, rem_tens, rem_units} !== ((k == 4) ? 12'h104 : (k == 20) ? 12'h100 : 12'h059)) begin
          n_bad++; $display("FAIL step_k%0d: got %h", k, {rem_min, rem_tens, rem_units});
        end
      end
      if (done) begin done_k = k; break; end
    end
    n_cmp++;
    if (done_k != 260) begin
      n_bad++; $display("FAIL done_cycle: got %0d expected 260", done_k);
    end
    beep_n = 0; done_n = 0;
    for (int i = 0; i < 20 && state == 2'd3; i++) begin
      if (beep) beep_n++;
      if (done) done_n++;
      cycle();
    end
    n_cmp++;
    if (beep_n != 8 || done_n != 1 || state !== 2'd0 || beep !== 1'b0) begin
      n_bad++; $display("FAIL beep_window: got beep %0d done %0d state %0d expected 8 1 0", beep_n, done_n, state);
    end
  endtask

  task automatic test_one_sec();
    int heat_n, done_k;
    begin_run(0, 0, 1);
    heat_n = 0; done_k = -1;
    for (int k = 0; k <= 10; k++) begin
      if (heater) heat_n++;
      if (done && done_k < 0) done_k = k;
      cycle();
    end
    n_cmp++;
    if (heat_n != 4 || done_k != 4) begin
      n_bad++; $display("FAIL one_sec: got heat %0d done_at %0d expected 4 4", heat_n, done_k);
    end
  endtask

  task automatic test_pause();
    int low_bad;
    logic [11:0] r19, r21, r22;
    logic [1:0] s6;
    logic h20;
    begin_run(0, 3, 0);
    low_bad = 0; r19 = '0; r21 = '0; r22 = '0; s6 = '0; h20 = 1'b0;
    for (int k = 1; k <= 24; k++) begin
      stop  = (k == 6);
      start = (k == 20);
      cycle();
      if (k >= 6 && k <= 19 && heater) low_bad++;
      if (k == 6)  s6 = state;
      if (k == 19) r19 = {rem_min, rem_tens, rem_units};
      if (k == 20) h20 = heater;
      if (k == 21) r21 = {rem_min, rem_tens, rem_units};
      if (k == 22) r22 = {rem_min, rem_tens, rem_units};
    end
    stop = 1'b0; start = 1'b0;
    n_cmp++;
    if (low_bad != 0 || s6 !== 2'd2 || h20 !== 1'b1) begin
      n_bad++; $display("FAIL pause_heater: got low_bad %0d state6 %0d heater20 %b expected 0 2 1", low_bad, s6, h20);
    end
    n_cmp++;
    if ({r19, r21, r22} !== {12'h029, 12'h029, 12'h028}) begin
      n_bad++; $display("FAIL pause_resume: got %h %h %h expected 029 029 028", r19, r21, r22);
    end
  endtask

  task automatic test_invalid();
    settle();
    set_time(0, 0, 0);
    cycle(); cycle();
    start = 1'b1; cycle(); start = 1'b0;
    n_cmp++;
    if ({state, heater} !== 3'b000) begin
      n_bad++; $display("FAIL zero_start: got %b expected %b", {state, heater}, 3'b000);
    end
    set_time(0, 6, 0);
    cycle();
    n_cmp++;
    if ({input_err, rem_min, rem_tens, rem_units} !== {1'b1, 12'h060}) begin
      n_bad++; $display("FAIL err_flag: got %h expected %h", {input_err, rem_min, rem_tens, rem_units}, {1'b1, 12'h060});
    end
    start = 1'b1; cycle(); cycle(); start = 1'b0;
    n_cmp++;
    if ({state, heater} !== 3'b000) begin
      n_bad++; $display("FAIL err_start: got %b expected %b", {state, heater}, 3'b000);
    end
    set_time(0, 5, 9);
    cycle();
    n_cmp++;
    if (input_err !== 1'b0) begin
      n_bad++; $display("FAIL err_clear: got %b expected 0", input_err);
    end
  endtask

  task automatic test_clear_start();
    begin_run(0, 1, 0);
    repeat (5) cycle();
    clear = 1'b1; start = 1'b1;
    cycle();
    clear = 1'b0; start = 1'b0;
    n_cmp++;
    if ({state, heater} !== 3'b000) begin
      n_bad++; $display("FAIL clear_start: got %b expected %b", {state, heater}, 3'b000);
    end
    set_time(0, 0, 8);
    cycle();
    n_cmp++;
    if ({rem_min, rem_tens, rem_units} !== 12'h008) begin
      n_bad++; $display("FAIL clear_reload: got %h expected 008", {rem_min, rem_tens, rem_units});
    end
  endtask

  task automatic test_async_reset();
    begin_run(0, 2, 0);
    repeat (6) cycle();
    #2 rst = 1'b0;
    #1;
    n_cmp++;
    if (actual() !== 18'd0) begin
      n_bad++; $display("FAIL async_reset: got %h expected %h", actual(), 18'd0);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    model_init();
  endtask

  task automatic test_door();
    begin_run(0, 1, 0);
    repeat (3) cycle();
    door_open = 1'b1;
    cycle();
`ifdef DOOR_INTERLOCK_EN
    n_cmp++;
    if ({state, heater} !== 3'b100) begin
      n_bad++; $display("FAIL door_pause: got %b expected %b", {state, heater}, 3'b100);
    end
    start = 1'b1; cycle();
    n_cmp++;
    if (state !== 2'd2) begin
      n_bad++; $display("FAIL door_start: got %0d expected 2", state);
    end
    door_open = 1'b0; cycle(); start = 1'b0;
    n_cmp++;
    if ({state, heater} !== 3'b011) begin
      n_bad++; $display("FAIL door_resume: got %b expected %b", {state, heater}, 3'b011);
    end
`else
    n_cmp++;
    if ({state, heater} !== 3'b011) begin
      n_bad++; $display("FAIL door_ignored: got %b expected %b", {state, heater}, 3'b011);
    end
`endif
    door_open = 1'b0;
  endtask

  task automatic test_random();
    logic [17:0] exp_v, act_v;
    for (int it = 0; it < 10; it++) begin
      settle();
      set_time(($urandom_range(0, 3) == 0) ? 1 : 0,
               ($urandom_range(0, 7) == 0) ? 6 : $urandom_range(0, 2),
               $urandom_range(0, 10));
      for (int c = 0; c < 200; c++) begin
        start     = ($urandom_range(0, 5) == 0);
        stop      = ($urandom_range(0, 15) == 0);
        clear     = ($urandom_range(0, 79) == 0);
        door_open = ($urandom_range(0, 19) == 0);
        if ($urandom_range(0, 15) == 0)
          set_time($urandom_range(0, 1), $urandom_range(0, 6), $urandom_range(0, 10));
        cycle();
        exp_v = expected();
        act_v = actual();
        n_cmp++;
        if (act_v !== exp_v) begin
          n_bad++; $display("FAIL random it%0d c%0d: got %h expected %h", it, c, act_v, exp_v);
        end
      end
    end
    start = 1'b0; stop = 1'b0; clear = 1'b0; door_open = 1'b0;
  endtask

  initial begin
    model_init();
    test_reset();
    test_full_run();
    test_one_sec();
    test_pause();
    test_invalid();
    test_clear_start();
    test_async_reset();
    test_door();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
